uart_tx_arbiter: RTL and testbench

Shares the single `tx_serial` transmitter between two byte sources (A: CPU I/O port, B: debug/status stream) inside `jtop`. Accepts bytes over valid/ready handshakes, arbitrates between sources, and sequences `tx_serial` through its `send`/`busy` protocol, one byte at a time. Multi-byte messages can be kept atomic with a per-port `last` flag so the two streams never interleave mid-message.

---
 rtl/uart_tx_arbiter_if.sv | 51 +++++
 rtl/uart_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Groups the signals between the two byte sources, the uart_tx_arbiter and
// the shared tx_serial transmitter.
//
//   a_data/a_valid/a_last  port A byte, byte-available flag, end-of-message flag
//   a_ready                port A byte accepted this cycle
//   b_data/b_valid/b_last  port B byte, byte-available flag, end-of-message flag
//   b_ready                port B byte accepted this cycle
//   sbyte                  byte handed to tx_serial
//   send                   one-cycle start strobe to tx_serial
//   busy                   tx_serial busy
//   grant                  one-hot current owner {B,A}, 0 when no owner
//   err_timeout            one-cycle pulse when busy never rose after send
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (sources and transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_last;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_last;
    logic       b_ready;
    logic [7:0] sbyte;
    logic       send;
    logic       busy;
    logic [1:0] grant;
    logic       err_timeout;

    modport slave (
        input  a_data, a_valid, a_last,
        input  b_data, b_valid, b_last,
        input  busy,
        output a_ready, b_ready,
        output sbyte, send, grant, err_timeout
    );

    modport master (
        output a_data, a_valid, a_last,
        output b_data, b_valid, b_last,
        output busy,
        input  a_ready, b_ready,
        input  sbyte, send, grant, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one tx_serial transmitter between two byte sources. Bytes arrive on
// valid/ready handshakes, one source wins per frame, and the winner's byte is
// launched with a one-cycle send strobe. A byte with last=0 locks the
// transmitter to its source so multi-byte messages are never interleaved.
//
// Parameters:
//   BUSY_WAIT  cycles allowed after send for busy to rise
//   LOCK_IDLE  cycles a locked owner may idle before the lock is dropped
//
// Ports:
//   clk100  system clock
//   reset   synchronous, active-high reset
//   bus     uart_tx_arbiter_if.slave (ports A/B, tx_serial side, status)
//
// Build option:
//   UART_TXARB_RR_EN  defined   -> round-robin between unlocked contenders
//                     undefined -> fixed priority, port A wins
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int BUSY_WAIT = 16,
    parameter int LOCK_IDLE = 200000
) (
    input  logic              clk100,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    localparam int BW_W = $clog2(BUSY_WAIT + 1);
    localparam int LI_W = $clog2(LOCK_IDLE + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      sbyte_q, sbyte_d;
    logic            send_q, send_d;
    logic [1:0]      grant_q, grant_d;
    logic            err_q, err_d;
    logic            lock_q, lock_d;
    logic [BW_W-1:0] busy_tmr_q, busy_tmr_d;
    logic [LI_W-1:0] idle_tmr_q, idle_tmr_d;
`ifdef UART_TXARB_RR_EN
    logic            last_b_q, last_b_d;
`endif

    logic pick_a;
    logic pick_b;
    logic owner_valid;

    // Winner selection. A pick is only possible in IDLE with the transmitter
    // free, so a pick doubles as the ready output and as the accept strobe
    // (a pick also implies valid). Ready is held low during the reset cycle.
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (state_q == IDLE && !bus.busy && !reset) begin
            if (lock_q) begin
                pick_a = grant_q[0] & bus.a_valid;
                pick_b = grant_q[1] & bus.b_valid;
            end else if (bus.a_valid && bus.b_valid) begin
`ifdef UART_TXARB_RR_EN
                pick_a = last_b_q;
                pick_b = ~last_b_q;
`else
                pick_a = 1'b1;
`endif
            end else begin
                pick_a = bus.a_valid;
                pick_b = bus.b_valid;
            end
        end
    end

    assign owner_valid = (grant_q[0] & bus.a_valid) | (grant_q[1] & bus.b_valid);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        sbyte_d    = sbyte_q;
        send_d     = 1'b0;
        grant_d    = grant_q;
        err_d      = 1'b0;
        lock_d     = lock_q;
        busy_tmr_d = busy_tmr_q;
        idle_tmr_d = idle_tmr_q;
`ifdef UART_TXARB_RR_EN
        last_b_d   = last_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_a || pick_b) begin
                    sbyte_d    = pick_a ? bus.a_data : bus.b_data;
                    send_d     = 1'b1;
                    grant_d    = pick_a ? 2'b01 : 2'b10;
                    lock_d     = pick_a ? ~bus.a_last : ~bus.b_last;
                    busy_tmr_d = '0;
                    idle_tmr_d = '0;
                    state_d    = WAIT_BUSY;
`ifdef UART_TXARB_RR_EN
                    last_b_d   = pick_b;
`endif
                end else if (lock_q) begin
                    // A silent owner must not starve the other port forever.
                    if (owner_valid) begin
                        idle_tmr_d = '0;
                    end else if (idle_tmr_q == LI_W'(LOCK_IDLE - 1)) begin
                        lock_d     = 1'b0;
                        grant_d    = 2'b00;
                        idle_tmr_d = '0;
                    end else begin
                        idle_tmr_d = idle_tmr_q + LI_W'(1);
                    end
                end else begin
                    idle_tmr_d = '0;
                end
            end

            WAIT_BUSY: begin
                // Busy is honoured on the same edge the timer would expire,
                // so a late-but-present busy still wins over the timeout.
                if (bus.busy) begin
                    busy_tmr_d = '0;
                    state_d    = WAIT_DONE;
                end else if (busy_tmr_q == BW_W'(BUSY_WAIT - 1)) begin
                    err_d      = 1'b1;
                    lock_d     = 1'b0;
                    grant_d    = 2'b00;
                    busy_tmr_d = '0;
                    state_d    = IDLE;
                end else begin
                    busy_tmr_d = busy_tmr_q + BW_W'(1);
                end
            end

            WAIT_DONE: begin
                if (!bus.busy) begin
                    if (!lock_q) begin
                        grant_d = 2'b00;
                    end
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q    <= IDLE;
            sbyte_q    <= 8'h00;
            send_q     <= 1'b0;
            grant_q    <= 2'b00;
            err_q      <= 1'b0;
            lock_q     <= 1'b0;
            busy_tmr_q <= '0;
            idle_tmr_q <= '0;
`ifdef UART_TXARB_RR_EN
            last_b_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            sbyte_q    <= sbyte_d;
            send_q     <= send_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
            lock_q     <= lock_d;
            busy_tmr_q <= busy_tmr_d;
            idle_tmr_q <= idle_tmr_d;
`ifdef UART_TXARB_RR_EN
            last_b_q   <= last_b_d;
`endif
        end
    end

    assign bus.a_ready     = pick_a;
    assign bus.b_ready     = pick_b;
    assign bus.sbyte       = sbyte_q;
    assign bus.send        = send_q;
    assign bus.grant       = grant_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. A reference model tracks message
// ownership and last-served port at the level of whole accepts and predicts
// the winner of every handshake; a tx_serial model answers send with a busy
// frame and logs the bytes it was handed. Directed sections cover reset,
// timeout, lock idle release and reset during a frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic clk100 = 1'b0;
    logic reset;
    logic txAuto;
    logic busyAuto;
    logic busyManual;
    logic txActive;

    int checkCount = 0;
    int errorCount = 0;
    int sendCount;
    logic [7:0] lastSentByte;
    logic [1:0] lastSentGrant;

    int modelOwner;
    bit modelLastB;

    logic [8:0] qA[$];
    logic [8:0] qB[$];
    logic [7:0] sentBytes[$];
    logic [1:0] sentGrant[$];
    logic [7:0] expBytes[$];
    logic [1:0] expGrant[$];
    int         accOrder[$];

    uart_tx_arbiter_if bus ();

    assign bus.busy = txAuto ? busyAuto : busyManual;

    uart_tx_arbiter #(
        .BUSY_WAIT(16),
        .LOCK_IDLE(50)
    ) dut (
        .clk100(clk100),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk100 = ~clk100;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // tx_serial model: busy rises 0..3 cycles after send and lasts 4..10 cycles.
    initial begin : txModel
        int dly;
        int flen;
        busyAuto  = 1'b0;
        txActive  = 1'b0;
        sendCount = 0;
        forever begin
            @(posedge clk100); #1;
            if (txAuto && bus.send) begin
                txActive = 1'b1;
                sendCount++;
                lastSentByte  = bus.sbyte;
                lastSentGrant = bus.grant;
                sentBytes.push_back(bus.sbyte);
                sentGrant.push_back(bus.grant);
                dly  = $urandom_range(0, 3);
                flen = $urandom_range(4, 10);
                repeat (dly) begin @(posedge clk100); #1; end
                busyAuto = 1'b1;
                repeat (flen) begin @(posedge clk100); #1; end
                busyAuto = 1'b0;
                txActive = 1'b0;
            end
        end
    end

    task automatic applyReset(input bit checkState);
        reset       = 1'b1;
        busyManual  = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h5A;
        bus.a_last  = 1'b1;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'hA5;
        bus.b_last  = 1'b1;
        @(posedge clk100); #1;
        @(negedge clk100);
        if (checkState) begin
            checkOutput("rst_a_ready", 32'(bus.a_ready), 32'd0);
            checkOutput("rst_b_ready", 32'(bus.b_ready), 32'd0);
            checkOutput("rst_sbyte", 32'(bus.sbyte), 32'd0);
            checkOutput("rst_send", 32'(bus.send), 32'd0);
            checkOutput("rst_grant", 32'(bus.grant), 32'd0);
            checkOutput("rst_err", 32'(bus.err_timeout), 32'd0);
        end
        @(posedge clk100); #1;
        reset       = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        modelOwner  = 0;
        modelLastB  = 1'b1;
        qA.delete();
        qB.delete();
        sentBytes.delete();
        sentGrant.delete();
        expBytes.delete();
        expGrant.delete();
        accOrder.delete();
    endtask

    // Drives the queued bytes of both ports, predicts each accept with the
    // ownership model and matches the transmitter log against predictions.
    task automatic applyStimulus(input int budget, input bit randGaps,
                                 input int holdA, input int holdB);
        int cyc;
        int gapA;
        int gapB;
        int win;
        int expWin;
        bit accA;
        bit accB;
        bit prevSend;
        logic [8:0] head;
        cyc      = 0;
        gapA     = holdA;
        gapB     = holdB;
        prevSend = 1'b0;
        while ((qA.size() > 0 || qB.size() > 0 || expBytes.size() > 0 || txActive)
               && cyc < budget) begin
            if (gapA > 0 || qA.size() == 0) begin
                if (gapA > 0) gapA--;
                bus.a_valid = 1'b0;
                bus.a_data  = 8'($urandom);
                bus.a_last  = 1'($urandom);
            end else begin
                bus.a_valid = 1'b1;
                bus.a_data  = qA[0][7:0];
                bus.a_last  = qA[0][8];
            end
            if (gapB > 0 || qB.size() == 0) begin
                if (gapB > 0) gapB--;
                bus.b_valid = 1'b0;
                bus.b_data  = 8'($urandom);
                bus.b_last  = 1'($urandom);
            end else begin
                bus.b_valid = 1'b1;
                bus.b_data  = qB[0][7:0];
                bus.b_last  = qB[0][8];
            end

            @(negedge clk100);
            checkOutput("one_ready", 32'(bus.a_ready & bus.b_ready), 32'd0);
            checkOutput("ready_while_busy", 32'((bus.a_ready | bus.b_ready) & bus.busy), 32'd0);
            checkOutput("ready_without_valid",
                        32'((bus.a_ready & ~bus.a_valid) | (bus.b_ready & ~bus.b_valid)), 32'd0);
            checkOutput("send_one_cycle", 32'(bus.send & prevSend), 32'd0);
            prevSend = bus.send;
            accA = bus.a_valid & bus.a_ready;
            accB = bus.b_valid & bus.b_ready;
            if (accA || accB) begin
                win = accA ? (accB ? 3 : 1) : 2;
                if (modelOwner != 0) begin
                    expWin = modelOwner;
                end else if (bus.a_valid && bus.b_valid) begin
`ifdef UART_TXARB_RR_EN
                    expWin = modelLastB ? 1 : 2;
`else
                    expWin = 1;
`endif
                end else begin
                    expWin = bus.a_valid ? 1 : 2;
                end
                checkOutput("winner", 32'(win), 32'(expWin));
                head = (win == 2) ? qB[0] : qA[0];
                expBytes.push_back(head[7:0]);
                expGrant.push_back((win == 2) ? 2'b10 : 2'b01);
                accOrder.push_back(win);
                modelOwner = head[8] ? 0 : win;
                modelLastB = (win == 2);
            end

            @(posedge clk100); #1;
            if (accA) begin
                void'(qA.pop_front());
                gapA = randGaps ? $urandom_range(0, 3) : 0;
            end
            if (accB) begin
                void'(qB.pop_front());
                gapB = randGaps ? $urandom_range(0, 3) : 0;
            end
            while (sentBytes.size() > 0) begin
                checkOutput("send_expected", 32'(expBytes.size() > 0), 32'd1);
                if (expBytes.size() > 0) begin
                    checkOutput("sbyte", 32'(sentBytes.pop_front()), 32'(expBytes.pop_front()));
                    checkOutput("grant_at_send", 32'(sentGrant.pop_front()),
                                32'(expGrant.pop_front()));
                end else begin
                    void'(sentBytes.pop_front());
                    void'(sentGrant.pop_front());
                end
            end
            cyc++;
        end
        checkOutput("phase_budget", 32'(cyc < budget), 32'd1);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (2) begin @(posedge clk100); #1; end
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int expOrder[6];
        int sendBase;
        int total;
        int nb;
        reset       = 1'b1;
        txAuto      = 1'b0;
        busyManual  = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.a_data  = 8'h00;
        bus.b_data  = 8'h00;
        bus.a_last  = 1'b0;
        bus.b_last  = 1'b0;

        $display("[TB] reset values");
        applyReset(1'b1);

        $display("[TB] single byte");
        applyReset(1'b0);
        txAuto   = 1'b1;
        sendBase = sendCount;
        qA.push_back({1'b1, 8'h41});
        applyStimulus(500, 1'b0, 0, 0);
        checkOutput("single_send_count", 32'(sendCount - sendBase), 32'd1);
        checkOutput("single_sbyte", 32'(lastSentByte), 32'h41);
        checkOutput("single_grant_on", 32'(lastSentGrant), 32'd1);
        checkOutput("single_grant_off", 32'(bus.grant), 32'd0);

        $display("[TB] contention");
        applyReset(1'b0);
        txAuto = 1'b1;
        for (int i = 0; i < 3; i++) begin
            qA.push_back({1'b1, 8'h41});
            qB.push_back({1'b1, 8'h42});
        end
        applyStimulus(2000, 1'b0, 0, 0);
`ifdef UART_TXARB_RR_EN
        expOrder = '{1, 2, 1, 2, 1, 2};
`else
        expOrder = '{1, 1, 1, 2, 2, 2};
`endif
        checkOutput("contend_count", 32'(accOrder.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("contend_order%0d", i), 32'(accOrder[i]), 32'(expOrder[i]));
        end

        $display("[TB] lock held by A");
        applyReset(1'b0);
        txAuto = 1'b1;
        qA.push_back({1'b0, 8'h48});
        qA.push_back({1'b0, 8'h49});
        qA.push_back({1'b1, 8'h0A});
        qB.push_back({1'b1, 8'h78});
        qB.push_back({1'b1, 8'h79});
        applyStimulus(2000, 1'b0, 0, 0);
        checkOutput("lockA_count", 32'(accOrder.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("lockA_order%0d", i), 32'(accOrder[i]), (i < 3) ? 32'd1 : 32'd2);
        end

        $display("[TB] lock held by B");
        applyReset(1'b0);
        txAuto = 1'b1;
        qB.push_back({1'b0, 8'h6F});
        qB.push_back({1'b0, 8'h6B});
        qB.push_back({1'b1, 8'h0A});
        qA.push_back({1'b1, 8'h7A});
        applyStimulus(2000, 1'b0, 1, 0);
        checkOutput("lockB_count", 32'(accOrder.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("lockB_order%0d", i), 32'(accOrder[i]), (i < 3) ? 32'd2 : 32'd1);
        end

        $display("[TB] randomized traffic");
        applyReset(1'b0);
        txAuto = 1'b1;
        total  = 0;
        for (int m = 0; m < 10; m++) begin
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) qA.push_back({1'(k == nb - 1), 8'($urandom)});
            total += nb;
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) qB.push_back({1'(k == nb - 1), 8'($urandom)});
            total += nb;
        end
        applyStimulus(8000, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2));
        checkOutput("rand_accepts", 32'(accOrder.size()), 32'(total));

        $display("[TB] busy timeout");
        applyReset(1'b0);
        txAuto      = 1'b0;
        busyManual  = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h33;
        bus.a_last  = 1'b0;
        @(negedge clk100);
        checkOutput("to_a_ready", 32'(bus.a_ready), 32'd1);
        @(posedge clk100); #1;
        checkOutput("to_send", 32'(bus.send), 32'd1);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h44;
        bus.b_last  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk100); #1;
            if (k == 5)  checkOutput("to_b_wait", 32'(bus.b_ready), 32'd0);
            if (k == 15) checkOutput("to_err_early", 32'(bus.err_timeout), 32'd0);
            if (k == 16) begin
                checkOutput("to_err_pulse", 32'(bus.err_timeout), 32'd1);
                checkOutput("to_grant_clear", 32'(bus.grant), 32'd0);
                checkOutput("to_b_ready", 32'(bus.b_ready), 32'd1);
            end
        end
        @(posedge clk100); #1;
        checkOutput("to_err_drop", 32'(bus.err_timeout), 32'd0);
        checkOutput("to_next_send", 32'(bus.send), 32'd1);
        checkOutput("to_next_sbyte", 32'(bus.sbyte), 32'h44);
        checkOutput("to_next_grant", 32'(bus.grant), 32'd2);
        bus.b_valid = 1'b0;

        $display("[TB] lock idle release");
        applyReset(1'b0);
        txAuto      = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h55;
        bus.a_last  = 1'b0;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h66;
        bus.b_last  = 1'b1;
        @(negedge clk100);
        checkOutput("li_a_ready", 32'(bus.a_ready), 32'd1);
        checkOutput("li_b_ready", 32'(bus.b_ready), 32'd0);
        @(posedge clk100); #1;
        bus.a_valid = 1'b0;
        busyManual  = 1'b1;
        @(posedge clk100); #1;
        busyManual = 1'b0;
        @(posedge clk100); #1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk100); #1;
            if (i == 49) begin
                checkOutput("li_grant_held", 32'(bus.grant), 32'd1);
                checkOutput("li_b_blocked", 32'(bus.b_ready), 32'd0);
            end
            if (i == 50) begin
                checkOutput("li_grant_released", 32'(bus.grant), 32'd0);
                checkOutput("li_b_ready", 32'(bus.b_ready), 32'd1);
            end
        end
        @(posedge clk100); #1;
        checkOutput("li_b_send", 32'(bus.send), 32'd1);
        checkOutput("li_b_sbyte", 32'(bus.sbyte), 32'h66);
        checkOutput("li_b_grant", 32'(bus.grant), 32'd2);
        bus.b_valid = 1'b0;

        $display("[TB] reset during WAIT_DONE");
        applyReset(1'b0);
        txAuto      = 1'b0;
        busyManual  = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h77;
        bus.a_last  = 1'b1;
        @(posedge clk100); #1;
        busyManual  = 1'b1;
        bus.a_valid = 1'b0;
        @(posedge clk100); #1;
        checkOutput("wd_grant", 32'(bus.grant), 32'd1);
        checkOutput("wd_sbyte", 32'(bus.sbyte), 32'h77);
        reset       = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h78;
        bus.a_last  = 1'b1;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h79;
        bus.b_last  = 1'b1;
        @(negedge clk100);
        checkOutput("mr_a_ready_rst", 32'(bus.a_ready), 32'd0);
        checkOutput("mr_b_ready_rst", 32'(bus.b_ready), 32'd0);
        @(posedge clk100); #1;
        reset      = 1'b0;
        modelOwner = 0;
        modelLastB = 1'b1;
        checkOutput("mr_grant", 32'(bus.grant), 32'd0);
        checkOutput("mr_sbyte", 32'(bus.sbyte), 32'd0);
        checkOutput("mr_send", 32'(bus.send), 32'd0);
        checkOutput("mr_err", 32'(bus.err_timeout), 32'd0);
        repeat (3) begin @(posedge clk100); #1; end
        @(negedge clk100);
        checkOutput("mr_hold_a", 32'(bus.a_ready), 32'd0);
        checkOutput("mr_hold_b", 32'(bus.b_ready), 32'd0);
        busyManual = 1'b0;
        #1;
        checkOutput("mr_resume_a", 32'(bus.a_ready), 32'd1);
        @(posedge clk100); #1;
        checkOutput("mr_resume_send", 32'(bus.send), 32'd1);
        checkOutput("mr_resume_sbyte", 32'(bus.sbyte), 32'h78);
        checkOutput("mr_resume_grant", 32'(bus.grant), 32'd1);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (20) begin @(posedge clk100); #1; end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
